core_ctrl_fsm: RTL
==================

// Module: core_ctrl_fsm
// PURPOSE
//  Multi-cycle sequencer for the RV32I core: fetches instructions, holds them in the IR feeding the
//  combinational instruction decoder, and steps EXEC / MEM / WB using decoder outputs.
//  Owns the PC, the memory handshakes, register-file write enable, retire count and sticky traps.
// PARAMETERS
//  RESET_PC      32'h0000_0000  PC value loaded on reset
//  IMEM_TIMEOUT  16             max FETCH wait cycles for imem_valid before trap
// PORTS
//  clk          in   1   rising-edge clock
//  rst_n        in   1   asynchronous active-low reset
//  imem_req     out  1   fetch request, held until imem_valid
//  imem_addr    out  32  fetch address (= pc)
//  imem_valid   in   1   fetch data valid this cycle
//  imem_rdata   in   32  fetched instruction
//  ir           out  32  instruction register, drives decoder instr
//  dec_opcode   in   17  decoder opcode {func7,func3,opcode}
//  dec_rd       in   5   decoder rd
//  dec_imm      in   32  decoder immediate
//  br_taken     in   1   ALU branch-condition result, valid in EXEC
//  alu_en       out  1   one-cycle ALU strobe in EXEC
//  dmem_req     out  1   data access request, held until dmem_ready
//  dmem_we      out  1   1 = store, 0 = load (qualified by dmem_req)
//  dmem_ready   in   1   data access complete this cycle
//  rf_we        out  1   one-cycle register-file write strobe
//  pc           out  32  current PC
//  retire       out  1   one-cycle pulse per completed instruction
//  instret      out  32  retired-instruction counter
//  trap         out  1   sticky fault flag
//  trap_cause   out  2   0 none, 1 fetch timeout, 2 misaligned PC, 3 illegal opcode
// BEHAVIOUR
//  Reset: state=FETCH, pc=RESET_PC, ir=32'h0000_0013 (NOP), instret=0, trap=0, cause=0, all strobes 0.
//  States: FETCH, DECODE, EXEC, MEM, WB, TRAP. Registered outputs; strobes decoded from state.
//  FETCH: if pc[1:0]!=0 -> TRAP (cause 2) without requesting. Otherwise imem_req=1, imem_addr=pc.
//   On imem_valid: ir<=imem_rdata, timeout counter cleared -> DECODE.
//   Counter +1 per waiting cycle; reaching IMEM_TIMEOUT without valid -> TRAP (cause 1).
//  DECODE (1 cycle): dec_opcode[6:0] must be one of 0110011, 0010011, 0000011, 0100011, 1100011,
//   0110111, 0010111, 1101111; otherwise -> TRAP (cause 3). Legal -> EXEC.
//  EXEC (1 cycle): alu_en=1; br_taken sampled into taken flag. Load/store -> MEM, else -> WB.
//  MEM: dmem_req=1, dmem_we=(store); held stable until dmem_ready, then -> WB. No timeout.
//  WB (1 cycle): rf_we=1 for R, I, load, LUI, AUIPC, JAL when dec_rd!=0; 0 for store/branch.
//   pc <= pc+dec_imm if JAL or (branch & taken), else pc+4; modulo 2^32 wrap.
//   retire=1, instret+1 (wraps 0xFFFF_FFFF->0) -> FETCH.
//  TRAP: terminal; trap=1, cause held, all strobes 0, pc frozen; exit only via rst_n.
//  Latency (zero-wait memories): ALU/branch/jump 4 cycles, load/store 5 cycles, FETCH to FETCH.
//  imem_valid outside FETCH and dmem_ready outside MEM are ignored.
//  Reset mid-operation: asynchronous, immediate return to reset values; outstanding requests dropped.
// TESTING
//  1. Reset, imem returns ADDI x1,x0,5 with 0 wait -> rf_we high in cycle 4, pc 0->4, instret=1.
//  2. SW followed by LW, dmem_ready after 3 cycles -> dmem_we 1/0, req held 3 cycles, rf_we only for LW.
//  3. BEQ imm=-8 at pc=0x10, br_taken=1 -> pc=0x08; br_taken=0 -> pc=0x14; rf_we never set.
//  4. Opcode 7'b1111111 -> trap=1, cause=3 after DECODE; later imem_valid pulses -> no state change.
//  5. imem_valid never asserted -> trap after 16 FETCH cycles, cause=1; rst_n low -> pc=RESET_PC, trap=0.
//  6. JAL imm=2 at pc=0 -> pc=2, next FETCH traps cause 2 with imem_req never asserted.

Source files
------------

// File: rtl/core_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I core.
// Owns PC, IR, the memory handshakes, retire counting and the sticky trap state.
module core_ctrl_fsm #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned IMEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    input  logic [16:0] dec_opcode,
    input  logic [4:0]  dec_rd,
    input  logic [31:0] dec_imm,
    input  logic        br_taken,
    output logic        alu_en,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ready,
    output logic        rf_we,
    output logic [31:0] pc,
    output logic        retire,
    output logic [31:0] instret,
    output logic        trap,
    output logic [1:0]  trap_cause
);

    localparam int unsigned CntW = $clog2(IMEM_TIMEOUT + 1);
    localparam logic [31:0] Nop  = 32'h0000_0013;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StTrap
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [31:0]     ir_q, ir_d;
    logic [31:0]     instret_q, instret_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            taken_q, taken_d;
    logic [1:0]      cause_q, cause_d;

    logic [6:0] op;
    logic       is_load, is_store, is_branch, is_jal, legal, writes_rd;
    logic       unused_func;

    // func7/func3 are not needed for sequencing; only the major opcode steers the FSM.
    assign unused_func = ^dec_opcode[16:7];
    assign op          = dec_opcode[6:0];

    always_comb begin
        is_load   = (op == 7'b0000011);
        is_store  = (op == 7'b0100011);
        is_branch = (op == 7'b1100011);
        is_jal    = (op == 7'b1101111);
        writes_rd = (op == 7'b0110011) || (op == 7'b0010011) || is_load ||
                    (op == 7'b0110111) || (op == 7'b0010111) || is_jal;
        legal     = writes_rd || is_store || is_branch;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StFetch;
            pc_q      <= RESET_PC;
            ir_q      <= Nop;
            instret_q <= '0;
            cnt_q     <= '0;
            taken_q   <= 1'b0;
            cause_q   <= 2'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            instret_q <= instret_d;
            cnt_q     <= cnt_d;
            taken_q   <= taken_d;
            cause_q   <= cause_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        instret_d = instret_q;
        cnt_d     = cnt_q;
        taken_d   = taken_q;
        cause_d   = cause_q;
        unique case (state_q)
            StFetch: begin
                if (pc_q[1:0] != 2'b00) begin
                    state_d = StTrap;
                    cause_d = 2'd2;
                end else if (imem_valid) begin
                    ir_d    = imem_rdata;
                    cnt_d   = '0;
                    state_d = StDecode;
                end else if (cnt_q == CntW'(IMEM_TIMEOUT - 1)) begin
                    // This is the last permitted waiting cycle.
                    state_d = StTrap;
                    cause_d = 2'd1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDecode: begin
                if (legal) begin
                    state_d = StExec;
                end else begin
                    state_d = StTrap;
                    cause_d = 2'd3;
                end
            end
            StExec: begin
                taken_d = br_taken;
                state_d = (is_load || is_store) ? StMem : StWb;
            end
            StMem: begin
                if (dmem_ready) begin
                    state_d = StWb;
                end
            end
            StWb: begin
                pc_d      = (is_jal || (is_branch && taken_q)) ? pc_q + dec_imm : pc_q + 32'd4;
                instret_d = instret_q + 32'd1;
                state_d   = StFetch;
            end
            StTrap: begin
                state_d = StTrap;
            end
            default: begin
                state_d = StTrap;
            end
        endcase
    end

    // Strobes are decoded from the registered state; decoder inputs are stable off the IR.
    always_comb begin
        imem_req   = (state_q == StFetch) && (pc_q[1:0] == 2'b00);
        imem_addr  = pc_q;
        ir         = ir_q;
        alu_en     = (state_q == StExec);
        dmem_req   = (state_q == StMem);
        dmem_we    = (state_q == StMem) && is_store;
        rf_we      = (state_q == StWb) && writes_rd && (dec_rd != 5'd0);
        pc         = pc_q;
        retire     = (state_q == StWb);
        instret    = instret_q;
        trap       = (state_q == StTrap);
        trap_cause = cause_q;
    end

endmodule
